// File: rtl/axis_matvec_pkg.sv
// Shared helpers for the streaming tiled matrix-vector accumulator.
//   w_p()     : per-tile partial-sum width (product width plus adder-tree growth)
//   w_y()     : accumulator / output element width (partial width plus tile growth)
//   latency() : tile pipeline depth (multiply stage plus adder-tree levels)
//   ext64()   : sign- or zero-extend the low w bits of a value to 64 bits
package axis_matvec_pkg;

    function automatic int unsigned w_p(input int unsigned w_x, input int unsigned w_k,
                                        input int unsigned c);
        return w_x + w_k + $clog2(c);
    endfunction

    function automatic int unsigned w_y(input int unsigned wp, input int unsigned max_tiles);
        return wp + $clog2(max_tiles);
    endfunction

    function automatic int unsigned latency(input int unsigned c);
        return $clog2(c) + 1;
    endfunction

    // Callers truncate the 64-bit result to their own width, so widths up to 64 are supported.
    function automatic logic [63:0] ext64(input logic [63:0] v, input int unsigned w,
                                          input bit sgn);
        logic [63:0] mask;
        logic        fill;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        fill = sgn && (((v >> (w - 1)) & 64'd1) != 64'd0);
        return fill ? (v | ~mask) : (v & mask);
    endfunction

endpackage

// File: rtl/matvec_tile_pipe.sv
// R x C tile multiplier with a registered binary adder tree, plus valid/last tracking.
//   cen_i            : advances every register in the pipe (data and valid/last alike)
//   valid_i, last_i  : beat qualifiers, delayed to valid_o / last_o with the data
//   data_i           : {k, x}; k row-major with row 0 in the LSBs, x element 0 in the LSBs
//   p_o              : per-row partial sums, row 0 in the LSBs
module matvec_tile_pipe
    import axis_matvec_pkg::*;
#(
    parameter int unsigned R      = 8,
    parameter int unsigned C      = 8,
    parameter int unsigned W_X    = 8,
    parameter int unsigned W_K    = 8,
    parameter bit          SIGNED = 1'b1,
    localparam int unsigned W_P   = w_p(W_X, W_K, C)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cen_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    input  logic [R*C*W_K+C*W_X-1:0] data_i,
    output logic                     valid_o,
    output logic                     last_o,
    output logic [R*W_P-1:0]         p_o
);

    localparam int unsigned LVLS    = $clog2(C);
    localparam int unsigned NP      = 1 << LVLS;
    localparam int unsigned LATENCY = latency(C);

    // Heap-ordered tree per row: node 1 is the root, leaves NP..2*NP-1 hold the products.
    logic [W_P-1:0] prod   [R][NP];
    logic [W_P-1:0] node_q [R][1:2*NP-1];
    logic [W_P-1:0] node_d [R][1:2*NP-1];
    logic [LATENCY-1:0] v_q, l_q;

    for (genvar r = 0; r < R; r++) begin : g_row
        for (genvar c = 0; c < NP; c++) begin : g_col
            if (c < C) begin : g_mul
                // Extending both operands to W_P first makes a W_P-bit product correct for
                // either signedness.
                assign prod[r][c] =
                    W_P'(ext64(64'(data_i[C*W_X + (r*C+c)*W_K +: W_K]), W_K, SIGNED)) *
                    W_P'(ext64(64'(data_i[c*W_X +: W_X]), W_X, SIGNED));
            end else begin : g_pad
                assign prod[r][c] = '0;
            end
        end
        assign p_o[r*W_P +: W_P] = node_q[r][1];
    end

    always_comb begin
        node_d = node_q;
        for (int r = 0; r < R; r++) begin
            for (int n = 1; n < NP; n++) begin
                node_d[r][n] = node_q[r][2*n] + node_q[r][2*n+1];
            end
            for (int n = 0; n < NP; n++) begin
                node_d[r][NP+n] = prod[r][n];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            node_q <= '{default: '0};
            v_q    <= '0;
            l_q    <= '0;
        end else if (cen_i) begin
            node_q <= node_d;
            v_q    <= LATENCY'({v_q, valid_i});
            l_q    <= LATENCY'({l_q, valid_i & last_i});
        end
    end

    assign valid_o = v_q[LATENCY-1];
    assign last_o  = l_q[LATENCY-1];

endmodule

// File: rtl/skid_buffer.sv
// Two-entry output register with a skid slot, giving a fully registered AXI-stream stage.
//   in_valid_i / in_ready_o / in_data_i   : upstream side; in_ready_o depends only on flops
//   out_valid_o / out_ready_i / out_data_o : downstream side; held stable while stalled
module skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             out_valid_q;
    logic [Width-1:0] out_data_q;
    logic             skid_valid_q;
    logic [Width-1:0] skid_data_q;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (out_ready_i || !out_valid_q) begin
            // Output slot is free: drain the skid first, otherwise take the input directly.
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    out_data_q <= in_data_i;
                end
            end
        end else if (in_valid_i && !skid_valid_q) begin
            // Output stalled: absorb the one word that was already in flight.
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data_i;
        end
    end

endmodule

// File: rtl/axis_matvec_acc.sv
// Streaming tiled matrix-vector multiplier: one R x C weight tile and C-element x slice per
// input beat, partial products accumulated across beats, one R-element y vector per packet.
//   clk, rstn                       : clock, asynchronous active-low reset
//   s_axis_kx_{tready,tvalid,tlast} : input handshake; tlast marks the final tile
//   s_axis_kx_tdata                 : {k, x}; k row-major, row 0 in LSBs; x element 0 in LSBs
//   m_axis_y_{tready,tvalid}        : output handshake
//   m_axis_y_tdata                  : y vector, row 0 in the LSBs
//   m_axis_y_tuser                  : set when the packet had more than MAX_TILES beats
module axis_matvec_acc
    import axis_matvec_pkg::*;
#(
    parameter int unsigned R         = 8,
    parameter int unsigned C         = 8,
    parameter int unsigned W_X       = 8,
    parameter int unsigned W_K       = 8,
    parameter int unsigned MAX_TILES = 16,
    parameter bit          SIGNED    = 1'b1,
    localparam int unsigned W_P      = w_p(W_X, W_K, C),
    localparam int unsigned W_Y      = w_y(W_P, MAX_TILES)
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     s_axis_kx_tready,
    input  logic                     s_axis_kx_tvalid,
    input  logic                     s_axis_kx_tlast,
    input  logic [R*C*W_K+C*W_X-1:0] s_axis_kx_tdata,
    input  logic                     m_axis_y_tready,
    output logic                     m_axis_y_tvalid,
    output logic [R*W_Y-1:0]         m_axis_y_tdata,
    output logic                     m_axis_y_tuser
);

    localparam int unsigned CW = $clog2(MAX_TILES + 1);

    logic             cen;
    logic             tail_v, tail_l;
    logic [R*W_P-1:0] tail_p;
    logic [R*W_Y-1:0] acc_q, sum;
    logic [CW-1:0]    count_q;
    logic             first_q, ovf_q, ovf_cur;
    logic [R*W_Y-1:0] y_q;
    logic             yv_q, yu_q;
    logic [R*W_Y:0]   out_data;

    // Whole datapath stalls together once the skid slot is occupied.
    assign s_axis_kx_tready = cen;

    matvec_tile_pipe #(
        .R      (R),
        .C      (C),
        .W_X    (W_X),
        .W_K    (W_K),
        .SIGNED (SIGNED)
    ) u_tile_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .cen_i   (cen),
        .valid_i (s_axis_kx_tvalid),
        .last_i  (s_axis_kx_tlast),
        .data_i  (s_axis_kx_tdata),
        .valid_o (tail_v),
        .last_o  (tail_l),
        .p_o     (tail_p)
    );

    always_comb begin
        sum = '0;
        for (int r = 0; r < R; r++) begin
            sum[r*W_Y +: W_Y] = W_Y'(ext64(64'(tail_p[r*W_P +: W_P]), W_P, SIGNED)) +
                                (first_q ? W_Y'(0) : acc_q[r*W_Y +: W_Y]);
        end
        // count_q == MAX_TILES means this beat is one past the limit.
        ovf_cur = (ovf_q & ~first_q) | (count_q == CW'(MAX_TILES));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q   <= '0;
            count_q <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else if (cen && tail_v) begin
            acc_q <= sum;
            if (tail_l) begin
                first_q <= 1'b1;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                first_q <= 1'b0;
                ovf_q   <= ovf_cur;
                // Saturate so very long packets keep the flag without the counter wrapping.
                if (count_q != CW'(MAX_TILES)) begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_q  <= '0;
            yv_q <= 1'b0;
            yu_q <= 1'b0;
        end else if (cen) begin
            yv_q <= tail_v & tail_l;
            if (tail_v && tail_l) begin
                y_q  <= sum;
                yu_q <= ovf_cur;
            end
        end
    end

    skid_buffer #(
        .Width (R*W_Y + 1)
    ) u_skid (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (yv_q),
        .in_ready_o  (cen),
        .in_data_i   ({yu_q, y_q}),
        .out_valid_o (m_axis_y_tvalid),
        .out_ready_i (m_axis_y_tready),
        .out_data_o  (out_data)
    );

    assign m_axis_y_tdata = out_data[R*W_Y-1:0];
    assign m_axis_y_tuser = out_data[R*W_Y];

endmodule
